pwm_symbol_encoder: RTL and testbench



---
 rtl/pwm_symbol_encoder.sv | 149 ++++++++++++++
 tb/tb_pwm_symbol_encoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_symbol_encoder.sv
// PWM symbol modulator: one 8-bit symbol becomes a fixed-length frame of +AMPL / -AMPL / 0 samples.
// Optional 4-entry input FIFO is built when PWM_ENC_SYMBOL_FIFO_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | no frame; output 0, waiting for a symbol
// S_PULSE | (s+1)*STEP samples of +AMPL
// S_SPACE | (255-s)*STEP samples of -AMPL (skipped for s=255)
// S_GUARD | GUARD samples of 0; last cycle may start next frame
module pwm_symbol_encoder #(
  parameter int                  STEP  = 1,
  parameter int                  GUARD = 16,
  parameter logic signed [15:0]  AMPL  = 16'sd95
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [7:0]         symbol_in,
  input  logic               symbol_valid,
  output logic               symbol_ready,
  output logic signed [15:0] sample_out,
  output logic               sample_valid,
  output logic               busy
);

  localparam int CW = $clog2(256 * STEP);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_SPACE, S_GUARD} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    sym;
  logic          at_boundary;
  logic          src_valid;
  logic [7:0]    src_data;
  logic          pop;

  function automatic logic [CW-1:0] span(input int n);
    return CW'(n * STEP - 1);
  endfunction

  assign at_boundary = (state == S_IDLE) || (state == S_GUARD && cnt == '0);
  assign pop         = enable && at_boundary && src_valid;
  assign busy        = (state != S_IDLE);

`ifdef PWM_ENC_SYMBOL_FIFO_EN
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] fifo_cnt;
  logic       push;

  // Writes do not depend on enable or FSM state; only fullness throttles the source.
  assign symbol_ready = reset_n && (fifo_cnt != 3'd4);
  assign push         = symbol_valid && symbol_ready;
  assign src_valid    = (fifo_cnt != 3'd0);
  assign src_data     = fifo_mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= symbol_in;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      fifo_cnt <= fifo_cnt + {2'b00, push} - {2'b00, pop};
    end
  end
`else
  assign symbol_ready = reset_n && enable && at_boundary;
  assign src_valid    = symbol_valid;
  assign src_data     = symbol_in;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      sym          <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else if (!enable) begin
      sample_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          sample_valid <= pop;
          if (pop) begin
            state      <= S_PULSE;
            sym        <= src_data;
            cnt        <= span(int'(src_data) + 1);
            sample_out <= AMPL;
          end
        end
        S_PULSE: begin
          sample_valid <= 1'b1;
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (sym == 8'hFF) begin
            state      <= S_GUARD;
            cnt        <= CW'(GUARD - 1);
            sample_out <= '0;
          end else begin
            state      <= S_SPACE;
            cnt        <= span(255 - int'(sym));
            sample_out <= -AMPL;
          end
        end
        S_SPACE: begin
          sample_valid <= 1'b1;
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            state      <= S_GUARD;
            cnt        <= CW'(GUARD - 1);
            sample_out <= '0;
          end
        end
        S_GUARD: begin
          if (cnt != '0) begin
            cnt          <= cnt - CW'(1);
            sample_valid <= 1'b1;
          end else if (pop) begin
            // back-to-back: next frame's first pulse directly follows the last guard sample
            state        <= S_PULSE;
            sym          <= src_data;
            cnt          <= span(int'(src_data) + 1);
            sample_out   <= AMPL;
            sample_valid <= 1'b1;
          end else begin
            state        <= S_IDLE;
            sample_valid <= 1'b0;
          end
        end
        default: begin
          state        <= S_IDLE;
          sample_out   <= '0;
          sample_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_symbol_encoder.sv
// Directed bench for pwm_symbol_encoder with default parameters (STEP=1, GUARD=16, AMPL=95).
module tb_pwm_symbol_encoder;

  localparam int AMPL = 95;

  logic               clock;
  logic               reset_n;
  logic               enable;
  logic [7:0]         symbol_in;
  logic               symbol_valid;
  logic               symbol_ready;
  logic signed [15:0] sample_out;
  logic               sample_valid;
  logic               busy;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  typedef struct {
    logic [7:0] sym;
    int         plus;
  } vec_t;

  vec_t vecs[4];

  pwm_symbol_encoder dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .symbol_in    (symbol_in),
    .symbol_valid (symbol_valid),
    .symbol_ready (symbol_ready),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic void push_frame(input logic [7:0] s);
    int si;
    si = int'(s);
    for (int i = 0; i < si + 1; i++)   exp_q.push_back(AMPL);
    for (int i = 0; i < 255 - si; i++) exp_q.push_back(-AMPL);
    for (int i = 0; i < 16; i++)       exp_q.push_back(0);
  endfunction

  // Issue a symbol from IDLE; optionally keep valid high with a follow-on symbol.
  task automatic start(input logic [7:0] s, input bit has_next, input logic [7:0] nxt);
    push_frame(s);
    symbol_in    = s;
    symbol_valid = 1'b1;
    #1 check("start_ready", int'(symbol_ready), 1);
    @(negedge clock);
    if (has_next) begin
      symbol_in = nxt;
      push_frame(nxt);
    end else begin
      symbol_valid = 1'b0;
    end
`ifdef PWM_ENC_SYMBOL_FIFO_EN
    check("fifo_latency_busy", int'(busy), 0);
    @(negedge clock);
    if (has_next) symbol_valid = 1'b0;
`endif
    check("first_pulse", int'(sample_out), AMPL);
    check("busy_up", int'(busy), 1);
  endtask

  // Walk the sample stream while busy, comparing valid samples against exp_q.
  task automatic collect(input int gap_at, input int gap_len,
                         output int n_valid, output int n_cyc, output int n_err,
                         output int n_plus, output int n_hold);
    int budget;
    bit pend;
    int last;
    n_valid = 0; n_cyc = 0; n_err = 0; n_plus = 0; n_hold = 0;
    budget  = 4000;
    last    = int'(sample_out);
    while (busy && budget > 0) begin
      if (sample_valid) begin
        n_valid++;
        if (int'(sample_out) == AMPL) n_plus++;
        if (exp_q.size() == 0) begin
          n_err++;
        end else begin
          if (int'(sample_out) != exp_q[0]) n_err++;
          void'(exp_q.pop_front());
        end
      end else begin
        n_hold++;
        if (int'(sample_out) != last) n_err++;
      end
      last = int'(sample_out);
      n_cyc++;
      enable = !(n_cyc > gap_at && n_cyc <= gap_at + gap_len);
      #1 pend = symbol_valid && symbol_ready;
      @(negedge clock);
      if (pend) symbol_valid = 1'b0;
      budget--;
    end
    if (budget == 0) n_err += 1000;
    enable = 1'b1;
  endtask

  initial begin
    int nv, nc, ne, np, nh;

    vecs[0] = '{sym: 8'd0,   plus: 1};
    vecs[1] = '{sym: 8'd255, plus: 256};
    vecs[2] = '{sym: 8'd100, plus: 101};
    vecs[3] = '{sym: 8'd37,  plus: 38};

    reset_n      = 1'b0;
    enable       = 1'b1;
    symbol_valid = 1'b1;
    symbol_in    = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("rst_sample_out", int'(sample_out), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_sample_valid", int'(sample_valid), 0);
      check("rst_ready", int'(symbol_ready), 0);
    end
    reset_n      = 1'b1;
    symbol_valid = 1'b0;
    #1 check("ready_after_release", int'(symbol_ready), 1);
    @(negedge clock);
    check("idle_after_release", int'(busy), 0);

`ifndef PWM_ENC_SYMBOL_FIFO_EN
    enable       = 1'b0;
    symbol_valid = 1'b1;
    #1 check("ready_enable_low", int'(symbol_ready), 0);
    @(negedge clock);
    check("no_accept_enable_low", int'(busy), 0);
    symbol_valid = 1'b0;
    enable       = 1'b1;
`endif

    for (int v = 0; v < 4; v++) begin
      start(vecs[v].sym, 1'b0, 8'h00);
      collect(100000, 0, nv, nc, ne, np, nh);
      check($sformatf("vec%0d_valid", v), nv, 272);
      check($sformatf("vec%0d_busy_cycles", v), nc, 272);
      check($sformatf("vec%0d_plus", v), np, vecs[v].plus);
      check($sformatf("vec%0d_holes", v), nh, 0);
      check($sformatf("vec%0d_seq_err", v), ne, 0);
      check($sformatf("vec%0d_leftover", v), exp_q.size(), 0);
      @(negedge clock);
    end

    start(8'h80, 1'b1, 8'h01);
    collect(100000, 0, nv, nc, ne, np, nh);
    check("b2b_valid", nv, 544);
    check("b2b_busy_cycles", nc, 544);
    check("b2b_plus", np, 131);
    check("b2b_seq_err", ne, 0);
    check("b2b_leftover", exp_q.size(), 0);
    @(negedge clock);

    start(8'd100, 1'b0, 8'h00);
    collect(50, 10, nv, nc, ne, np, nh);
    check("gap_valid", nv, 272);
    check("gap_busy_cycles", nc, 282);
    check("gap_plus", np, 101);
    check("gap_hold", nh, 10);
    check("gap_seq_err", ne, 0);
    @(negedge clock);

    start(8'd0, 1'b0, 8'h00);
    repeat (20) @(negedge clock);
    check("space_before_reset", int'(sample_out), -AMPL);
    reset_n      = 1'b0;
    symbol_valid = 1'b1;
    symbol_in    = 8'd9;
    @(negedge clock);
    check("midrst_sample_out", int'(sample_out), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_sample_valid", int'(sample_valid), 0);
    reset_n      = 1'b1;
    symbol_valid = 1'b0;
    @(negedge clock);
    check("midrst_not_resumed", int'(busy), 0);
    exp_q.delete();

`ifdef PWM_ENC_SYMBOL_FIFO_EN
    begin
      logic [7:0] fs [5];
      fs[0] = 8'd3; fs[1] = 8'd200; fs[2] = 8'd7; fs[3] = 8'd9; fs[4] = 8'd11;
      enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
        symbol_in    = fs[i];
        symbol_valid = 1'b1;
        #1 check($sformatf("fifo_ready%0d", i), int'(symbol_ready), (i < 4) ? 1 : 0);
        push_frame(fs[i]);
        if (i < 4) @(negedge clock);
      end
      enable = 1'b1;
      @(negedge clock);
      check("fifo_first_pulse", int'(sample_out), AMPL);
      collect(100000, 0, nv, nc, ne, np, nh);
      check("fifo_valid", nv, 1360);
      check("fifo_seq_err", ne, 0);
      check("fifo_leftover", exp_q.size(), 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
